// File: rtl/riscv_mpsoc_pkg.sv
// Shared types for the MPSoC debug infrastructure.
// The debug sequencer FSM state encoding is defined here so that any other
// block can decode the sequencer state with the same enum.
package riscv_mpsoc_pkg;

    typedef enum logic [1:0] {
        DBG_IDLE   = 2'd0,
        DBG_STALL  = 2'd1,
        DBG_ACCESS = 2'd2,
        DBG_RESP   = 2'd3
    } dbg_state_e;

endpackage : riscv_mpsoc_pkg

// File: rtl/riscv_dbg_stall_ctrl.sv
// Per-core sticky stall bank for the debug sequencer.
// A bit is set by the core's breakpoint or by a debug command and cleared by a
// resume request. When set and clear hit the same core in the same cycle, the
// set wins so that a breakpoint is never lost. The stall output also follows
// the live breakpoint input so the core halts in the very cycle it requests it.
module riscv_dbg_stall_ctrl #(
    parameter int CORES_PER_TILE = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [CORES_PER_TILE-1:0] bp,
    input  logic [CORES_PER_TILE-1:0] set_vec,
    input  logic [CORES_PER_TILE-1:0] clr_vec,
    output logic [CORES_PER_TILE-1:0] stall
);

    logic [CORES_PER_TILE-1:0] stall_r;

    // Sticky stall bits: set (breakpoint or command) has priority over clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_r <= '0;
        end else begin
            stall_r <= (stall_r & ~clr_vec) | bp | set_vec;
        end
    end

    // Stall seen by each core: live breakpoint or held sticky bit.
    always_comb begin
        stall = bp | stall_r;
    end

endmodule : riscv_dbg_stall_ctrl

// File: rtl/riscv_dbg_sequencer.sv
// Debug access sequencer: takes one host debug command at a time, stalls the
// target core, performs a single strobe/ack access on that core's debug port
// and returns a one-cycle response to the host.
// Optional feature: define RISCV_DBG_TIMEOUT_EN to bound the ack wait by
// TIMEOUT cycles; without it, the access waits for the ack indefinitely.
module riscv_dbg_sequencer
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int PLEN           = 64,
    parameter int CORES_PER_TILE = 16,
    parameter int TIMEOUT        = 255
) (
    input  logic                                   clk,
    input  logic                                   rstn,

    input  logic                                   host_req_valid,
    output logic                                   host_req_ready,
    input  logic [$clog2(CORES_PER_TILE):0]        host_req_core,
    input  logic                                   host_req_we,
    input  logic [PLEN-1:0]                        host_req_adr,
    input  logic [XLEN-1:0]                        host_req_dat,
    input  logic                                   host_req_resume,
    output logic                                   host_rsp_valid,
    output logic [XLEN-1:0]                        host_rsp_dat,
    output logic                                   host_rsp_err,

    input  logic [CORES_PER_TILE-1:0]              cpu_bp_i,
    output logic [CORES_PER_TILE-1:0]              cpu_stall_o,
    output logic [CORES_PER_TILE-1:0]              cpu_stb_o,
    output logic [CORES_PER_TILE-1:0]              cpu_we_o,
    output logic [CORES_PER_TILE*PLEN-1:0]         cpu_adr_o,
    output logic [CORES_PER_TILE*XLEN-1:0]         cpu_dat_o,
    input  logic [CORES_PER_TILE*XLEN-1:0]         cpu_dat_i,
    input  logic [CORES_PER_TILE-1:0]              cpu_ack_i
);

    localparam int CW = $clog2(CORES_PER_TILE) + 1;

    dbg_state_e                state_r;
    dbg_state_e                nxt_state_s;

    logic [CW-1:0]             core_r;
    logic                      we_r;
    logic [PLEN-1:0]           adr_r;
    logic [XLEN-1:0]           dat_r;
    logic                      resume_r;
    logic                      err_r;
    logic [XLEN-1:0]           rdata_r;
    logic                      stb_r;
    logic                      rsp_valid_r;
    logic [XLEN-1:0]           rsp_dat_r;
    logic                      rsp_err_r;

    logic                      core_ok_s;
    logic [CORES_PER_TILE-1:0] sel_s;
    logic                      ack_hit_s;
    logic                      tmo_hit_s;
    logic [XLEN-1:0]           rdat_sel_s;
    logic [CORES_PER_TILE-1:0] set_vec_s;
    logic [CORES_PER_TILE-1:0] clr_vec_s;

    // Decode of the captured core and the incoming index range check.
    always_comb begin
        core_ok_s = (host_req_core < CW'(CORES_PER_TILE));
        sel_s     = '0;
        for (int c = 0; c < CORES_PER_TILE; c++) begin
            sel_s[c] = (core_r == CW'(c));
        end
    end

    // Read-data mux and ack detection for the selected core only.
    always_comb begin
        rdat_sel_s = '0;
        for (int c = 0; c < CORES_PER_TILE; c++) begin
            rdat_sel_s = rdat_sel_s | (sel_s[c] ? cpu_dat_i[c*XLEN +: XLEN] : {XLEN{1'b0}});
        end
        ack_hit_s = stb_r && ((cpu_ack_i & sel_s) != '0);
    end

`ifdef RISCV_DBG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_r;

    // Count cycles spent in ACCESS; restarts whenever the FSM leaves it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_r <= '0;
        end else if (state_r == DBG_ACCESS) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Timeout fires on the TIMEOUT-th ACCESS cycle unless the ack arrives then.
    always_comb begin
        tmo_hit_s = (state_r == DBG_ACCESS) && (tmo_cnt_r == TW'(TIMEOUT - 1)) && !ack_hit_s;
    end
`else
    // No ack-wait limit: ACCESS only ends on an ack.
    always_comb begin
        tmo_hit_s = 1'b0;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= DBG_IDLE;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // FSM next-state logic; an out-of-range core skips straight to RESP.
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            DBG_IDLE: begin
                if (host_req_valid) begin
                    nxt_state_s = core_ok_s ? DBG_STALL : DBG_RESP;
                end else begin
                    nxt_state_s = DBG_IDLE;
                end
            end
            DBG_STALL: begin
                nxt_state_s = DBG_ACCESS;
            end
            DBG_ACCESS: begin
                if (ack_hit_s || tmo_hit_s) begin
                    nxt_state_s = DBG_RESP;
                end else begin
                    nxt_state_s = DBG_ACCESS;
                end
            end
            DBG_RESP: begin
                nxt_state_s = DBG_IDLE;
            end
            default: begin
                nxt_state_s = DBG_IDLE;
            end
        endcase
    end

    // Capture the host command on acceptance and the access result on completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_r   <= '0;
            we_r     <= 1'b0;
            adr_r    <= '0;
            dat_r    <= '0;
            resume_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= '0;
        end else if ((state_r == DBG_IDLE) && host_req_valid) begin
            core_r   <= host_req_core;
            we_r     <= host_req_we;
            adr_r    <= host_req_adr;
            dat_r    <= host_req_dat;
            resume_r <= host_req_resume;
            err_r    <= !core_ok_s;
            rdata_r  <= '0;
        end else if (ack_hit_s) begin
            err_r    <= 1'b0;
            rdata_r  <= we_r ? {XLEN{1'b0}} : rdat_sel_s;
        end else if (tmo_hit_s) begin
            err_r    <= 1'b1;
            rdata_r  <= '0;
        end else begin
            rdata_r  <= rdata_r;
        end
    end

    // Strobe rises on the first ACCESS edge and drops on the ack/timeout edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stb_r <= 1'b0;
        end else if ((state_r == DBG_ACCESS) && !ack_hit_s && !tmo_hit_s) begin
            stb_r <= 1'b1;
        end else begin
            stb_r <= 1'b0;
        end
    end

    // Host response registers: valid for exactly the cycle after RESP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= '0;
            rsp_err_r   <= 1'b0;
        end else if (state_r == DBG_RESP) begin
            rsp_valid_r <= 1'b1;
            rsp_dat_r   <= rdata_r;
            rsp_err_r   <= err_r;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= '0;
            rsp_err_r   <= 1'b0;
        end
    end

    // Stall bank requests: set in STALL, clear in RESP only after a good access.
    always_comb begin
        set_vec_s = (state_r == DBG_STALL) ? sel_s : {CORES_PER_TILE{1'b0}};
        clr_vec_s = ((state_r == DBG_RESP) && resume_r && !err_r) ? sel_s : {CORES_PER_TILE{1'b0}};
    end

    riscv_dbg_stall_ctrl #(
        .CORES_PER_TILE (CORES_PER_TILE)
    ) u_stall_ctrl (
        .clk     (clk),
        .rstn    (rstn),
        .bp      (cpu_bp_i),
        .set_vec (set_vec_s),
        .clr_vec (clr_vec_s),
        .stall   (cpu_stall_o)
    );

    // Per-core bus drive: only the captured core sees strobe, address and data.
    always_comb begin
        cpu_stb_o = stb_r ? sel_s : {CORES_PER_TILE{1'b0}};
        cpu_we_o  = (stb_r && we_r) ? sel_s : {CORES_PER_TILE{1'b0}};
        cpu_adr_o = '0;
        cpu_dat_o = '0;
        for (int c = 0; c < CORES_PER_TILE; c++) begin
            cpu_adr_o[c*PLEN +: PLEN] = (stb_r && sel_s[c]) ? adr_r : {PLEN{1'b0}};
            cpu_dat_o[c*XLEN +: XLEN] = (stb_r && sel_s[c]) ? dat_r : {XLEN{1'b0}};
        end
    end

    // Host-side outputs.
    always_comb begin
        host_req_ready = (state_r == DBG_IDLE);
        host_rsp_valid = rsp_valid_r;
        host_rsp_dat   = rsp_dat_r;
        host_rsp_err   = rsp_err_r;
    end

endmodule : riscv_dbg_sequencer

// File: tb/tb_riscv_dbg_sequencer.sv
// Directed testbench for riscv_dbg_sequencer (16 cores, 64-bit data/address).
// With RISCV_DBG_TIMEOUT_EN defined the DUT is built with TIMEOUT=8.
module tb_riscv_dbg_sequencer;

    localparam int N  = 16;
    localparam int XL = 64;
    localparam int PL = 64;
`ifdef RISCV_DBG_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic            clk = 1'b0;
    logic            rstn;
    logic            host_req_valid;
    logic            host_req_ready;
    logic [4:0]      host_req_core;
    logic            host_req_we;
    logic [PL-1:0]   host_req_adr;
    logic [XL-1:0]   host_req_dat;
    logic            host_req_resume;
    logic            host_rsp_valid;
    logic [XL-1:0]   host_rsp_dat;
    logic            host_rsp_err;
    logic [N-1:0]    cpu_bp_i;
    logic [N-1:0]    cpu_stall_o;
    logic [N-1:0]    cpu_stb_o;
    logic [N-1:0]    cpu_we_o;
    logic [N*PL-1:0] cpu_adr_o;
    logic [N*XL-1:0] cpu_dat_o;
    logic [N*XL-1:0] cpu_dat_i;
    logic [N-1:0]    cpu_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    riscv_dbg_sequencer #(
        .XLEN(XL), .PLEN(PL), .CORES_PER_TILE(N), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_core(host_req_core), .host_req_we(host_req_we),
        .host_req_adr(host_req_adr), .host_req_dat(host_req_dat),
        .host_req_resume(host_req_resume),
        .host_rsp_valid(host_rsp_valid), .host_rsp_dat(host_rsp_dat),
        .host_rsp_err(host_rsp_err),
        .cpu_bp_i(cpu_bp_i), .cpu_stall_o(cpu_stall_o), .cpu_stb_o(cpu_stb_o),
        .cpu_we_o(cpu_we_o), .cpu_adr_o(cpu_adr_o), .cpu_dat_o(cpu_dat_o),
        .cpu_dat_i(cpu_dat_i), .cpu_ack_i(cpu_ack_i)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle at the falling edge for drive and sample.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a command for one accepting edge; returns after that edge.
    task automatic issue(input logic [4:0] core, input logic we, input logic [PL-1:0] adr,
                         input logic [XL-1:0] dat, input logic resume);
        host_req_valid  = 1'b1;
        host_req_core   = core;
        host_req_we     = we;
        host_req_adr    = adr;
        host_req_dat    = dat;
        host_req_resume = resume;
        tick();
        host_req_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #1;
        n_cmp++; if (host_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", host_req_ready); end
        n_cmp++; if (host_rsp_valid !== 1'b0 || host_rsp_err !== 1'b0 || host_rsp_dat !== 64'h0) begin n_err++; $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0/0/0", host_rsp_valid, host_rsp_err, host_rsp_dat); end
        n_cmp++; if (cpu_stb_o !== 16'h0 || cpu_we_o !== 16'h0 || cpu_stall_o !== 16'h0) begin n_err++; $display("FAIL reset_cpu: got stb=%h we=%h stall=%h expected 0", cpu_stb_o, cpu_we_o, cpu_stall_o); end
        n_cmp++; if (cpu_adr_o !== '0 || cpu_dat_o !== '0) begin n_err++; $display("FAIL reset_bus: got nonzero adr/dat expected 0"); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_write;
        logic [N*PL-1:0] ea;
        logic [N*XL-1:0] ed;
        ea = '0; ea[3*PL +: PL] = 64'h10;
        ed = '0; ed[3*XL +: XL] = 64'hA5;
        issue(5'd3, 1'b1, 64'h10, 64'hA5, 1'b0);
        n_cmp++; if (host_req_ready !== 1'b0) begin n_err++; $display("FAIL wr_busy: got ready=%b expected 0", host_req_ready); end
        tick();
        n_cmp++; if (cpu_stb_o !== 16'h0) begin n_err++; $display("FAIL wr_stb_early: got %h expected 0000", cpu_stb_o); end
        n_cmp++; if (cpu_stall_o[3] !== 1'b1) begin n_err++; $display("FAIL wr_stall_set: got %b expected 1", cpu_stall_o[3]); end
        tick();
        n_cmp++; if (cpu_stb_o !== 16'h0008 || cpu_we_o !== 16'h0008) begin n_err++; $display("FAIL wr_stb: got stb=%h we=%h expected 0008/0008", cpu_stb_o, cpu_we_o); end
        n_cmp++; if (cpu_adr_o !== ea || cpu_dat_o !== ed) begin n_err++; $display("FAIL wr_bus: got adr3=%h dat3=%h expected 10/a5 only on core 3", cpu_adr_o[3*PL +: PL], cpu_dat_o[3*XL +: XL]); end
        cpu_ack_i = 16'h0080;
        tick();
        n_cmp++; if (cpu_stb_o !== 16'h0008) begin n_err++; $display("FAIL wr_foreign_ack: got stb=%h expected 0008", cpu_stb_o); end
        cpu_ack_i = 16'h0000;
        tick();
        tick();
        n_cmp++; if (cpu_stb_o !== 16'h0008) begin n_err++; $display("FAIL wr_stb_hold: got %h expected 0008", cpu_stb_o); end
        cpu_ack_i = 16'h0008;
        tick();
        cpu_ack_i = 16'h0000;
        n_cmp++; if (cpu_stb_o !== 16'h0 || cpu_we_o !== 16'h0 || host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_ack_edge: got stb=%h we=%h v=%b expected 0/0/0", cpu_stb_o, cpu_we_o, host_rsp_valid); end
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_err !== 1'b0 || host_rsp_dat !== 64'h0) begin n_err++; $display("FAIL wr_rsp: got v=%b e=%b d=%h expected 1/0/0", host_rsp_valid, host_rsp_err, host_rsp_dat); end
        n_cmp++; if (cpu_stall_o[3] !== 1'b1) begin n_err++; $display("FAIL wr_stall_kept: got %b expected 1", cpu_stall_o[3]); end
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b0 || host_req_ready !== 1'b1) begin n_err++; $display("FAIL wr_rsp_pulse: got v=%b ready=%b expected 0/1", host_rsp_valid, host_req_ready); end
    endtask

    task automatic test_read_resume;
        cpu_dat_i[0*XL +: XL] = 64'h1234;
        cpu_dat_i[1*XL +: XL] = 64'hDEAD_BEEF;
        issue(5'd0, 1'b0, 64'h20, 64'h0, 1'b1);
        tick();
        tick();
        n_cmp++; if (cpu_stb_o !== 16'h0001 || cpu_we_o !== 16'h0000) begin n_err++; $display("FAIL rd_stb: got stb=%h we=%h expected 0001/0000", cpu_stb_o, cpu_we_o); end
        cpu_ack_i = 16'h0001;
        tick();
        cpu_ack_i = 16'h0000;
        n_cmp++; if (cpu_stall_o[0] !== 1'b1 || cpu_stb_o !== 16'h0) begin n_err++; $display("FAIL rd_pre_resp: got stall0=%b stb=%h expected 1/0000", cpu_stall_o[0], cpu_stb_o); end
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_err !== 1'b0 || host_rsp_dat !== 64'h1234) begin n_err++; $display("FAIL rd_rsp: got v=%b e=%b d=%h expected 1/0/1234", host_rsp_valid, host_rsp_err, host_rsp_dat); end
        n_cmp++; if (cpu_stall_o[0] !== 1'b0) begin n_err++; $display("FAIL rd_resume: got stall0=%b expected 0", cpu_stall_o[0]); end
        tick();
    endtask

    task automatic test_bad_index;
        logic [N-1:0] stall_before;
        stall_before = cpu_stall_o;
        issue(5'd16, 1'b1, 64'h30, 64'h55, 1'b1);
        n_cmp++; if (cpu_stb_o !== 16'h0 || host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL bad_early: got stb=%h v=%b expected 0000/0", cpu_stb_o, host_rsp_valid); end
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_err !== 1'b1 || host_rsp_dat !== 64'h0) begin n_err++; $display("FAIL bad_rsp: got v=%b e=%b d=%h expected 1/1/0", host_rsp_valid, host_rsp_err, host_rsp_dat); end
        n_cmp++; if (cpu_stb_o !== 16'h0 || cpu_stall_o !== stall_before) begin n_err++; $display("FAIL bad_side: got stb=%h stall=%h expected 0000/%h", cpu_stb_o, cpu_stall_o, stall_before); end
        tick();
    endtask

    task automatic test_bp_resume;
        issue(5'd5, 1'b0, 64'h40, 64'h0, 1'b1);
        tick();
        tick();
        cpu_ack_i = 16'h0020;
        tick();
        cpu_ack_i = 16'h0000;
        cpu_bp_i  = 16'h0020;
        tick();
        cpu_bp_i  = 16'h0000;
        #1;
        n_cmp++; if (host_rsp_valid !== 1'b1 || cpu_stall_o[5] !== 1'b1) begin n_err++; $display("FAIL bp_set_wins: got v=%b stall5=%b expected 1/1", host_rsp_valid, cpu_stall_o[5]); end
        cpu_bp_i = 16'h0200;
        #1;
        n_cmp++; if (cpu_stall_o[9] !== 1'b1) begin n_err++; $display("FAIL bp_live: got stall9=%b expected 1", cpu_stall_o[9]); end
        tick();
        cpu_bp_i = 16'h0000;
        #1;
        n_cmp++; if (cpu_stall_o[9] !== 1'b1) begin n_err++; $display("FAIL bp_sticky: got stall9=%b expected 1", cpu_stall_o[9]); end
    endtask

    task automatic test_back_to_back;
        issue(5'd1, 1'b0, 64'h50, 64'h0, 1'b0);
        tick();
        tick();
        cpu_ack_i = 16'h0002;
        tick();
        cpu_ack_i = 16'h0000;
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b1 || host_req_ready !== 1'b1 || host_rsp_dat !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL b2b_rsp: got v=%b ready=%b d=%h expected 1/1/deadbeef", host_rsp_valid, host_req_ready, host_rsp_dat); end
        issue(5'd1, 1'b1, 64'h58, 64'h77, 1'b1);
        n_cmp++; if (host_rsp_valid !== 1'b0 || host_req_ready !== 1'b0 || cpu_stall_o[1] !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got v=%b ready=%b stall1=%b expected 0/0/1", host_rsp_valid, host_req_ready, cpu_stall_o[1]); end
        tick();
        tick();
        n_cmp++; if (cpu_stb_o !== 16'h0002 || cpu_dat_o[1*XL +: XL] !== 64'h77) begin n_err++; $display("FAIL b2b_stb: got stb=%h dat1=%h expected 0002/77", cpu_stb_o, cpu_dat_o[1*XL +: XL]); end
        cpu_ack_i = 16'h0002;
        tick();
        cpu_ack_i = 16'h0000;
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_dat !== 64'h0 || cpu_stall_o[1] !== 1'b0) begin n_err++; $display("FAIL b2b_second: got v=%b d=%h stall1=%b expected 1/0/0", host_rsp_valid, host_rsp_dat, cpu_stall_o[1]); end
        tick();
    endtask

`ifdef RISCV_DBG_TIMEOUT_EN
    task automatic test_timeout;
        int hi_cnt;
        hi_cnt = 0;
        issue(5'd2, 1'b1, 64'h60, 64'h99, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            if (cpu_stb_o == 16'h0004) hi_cnt++;
        end
        n_cmp++; if (hi_cnt != 7) begin n_err++; $display("FAIL tmo_stb_hold: got %0d high cycles expected 7", hi_cnt); end
        tick();
        n_cmp++; if (cpu_stb_o !== 16'h0 || host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL tmo_drop: got stb=%h v=%b expected 0000/0", cpu_stb_o, host_rsp_valid); end
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_err !== 1'b1 || host_rsp_dat !== 64'h0) begin n_err++; $display("FAIL tmo_rsp: got v=%b e=%b d=%h expected 1/1/0", host_rsp_valid, host_rsp_err, host_rsp_dat); end
        n_cmp++; if (cpu_stall_o[2] !== 1'b1 || host_req_ready !== 1'b1) begin n_err++; $display("FAIL tmo_stall: got stall2=%b ready=%b expected 1/1", cpu_stall_o[2], host_req_ready); end
        issue(5'd2, 1'b0, 64'h60, 64'h0, 1'b1);
        tick();
        tick();
        cpu_ack_i = 16'h0004;
        tick();
        cpu_ack_i = 16'h0000;
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_err !== 1'b0 || cpu_stall_o[2] !== 1'b0) begin n_err++; $display("FAIL tmo_next: got v=%b e=%b stall2=%b expected 1/0/0", host_rsp_valid, host_rsp_err, cpu_stall_o[2]); end
        tick();
    endtask
`else
    task automatic test_no_timeout;
        int hi_cnt;
        hi_cnt = 0;
        issue(5'd2, 1'b1, 64'h60, 64'h99, 1'b1);
        tick();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (cpu_stb_o == 16'h0004 && host_rsp_valid == 1'b0) hi_cnt++;
        end
        n_cmp++; if (hi_cnt != 300) begin n_err++; $display("FAIL notmo_wait: got %0d waiting cycles expected 300", hi_cnt); end
        cpu_ack_i = 16'h0004;
        tick();
        cpu_ack_i = 16'h0000;
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_err !== 1'b0 || cpu_stall_o[2] !== 1'b0) begin n_err++; $display("FAIL notmo_rsp: got v=%b e=%b stall2=%b expected 1/0/0", host_rsp_valid, host_rsp_err, cpu_stall_o[2]); end
        tick();
    endtask
`endif

    task automatic test_reset_mid;
        issue(5'd4, 1'b1, 64'h70, 64'h11, 1'b1);
        tick();
        tick();
        n_cmp++; if (cpu_stb_o !== 16'h0010) begin n_err++; $display("FAIL rst_pre: got stb=%h expected 0010", cpu_stb_o); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (cpu_stb_o !== 16'h0 || cpu_stall_o !== 16'h0 || host_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid: got stb=%h stall=%h v=%b expected 0/0/0", cpu_stb_o, cpu_stall_o, host_rsp_valid); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++; if (host_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", host_req_ready); end
        tick();
        n_cmp++; if (host_rsp_valid !== 1'b0 || cpu_stb_o !== 16'h0) begin n_err++; $display("FAIL rst_norsp: got v=%b stb=%h expected 0/0000", host_rsp_valid, cpu_stb_o); end
    endtask

    initial begin
        rstn            = 1'b0;
        host_req_valid  = 1'b0;
        host_req_core   = 5'd0;
        host_req_we     = 1'b0;
        host_req_adr    = 64'h0;
        host_req_dat    = 64'h0;
        host_req_resume = 1'b0;
        cpu_bp_i        = 16'h0;
        cpu_ack_i       = 16'h0;
        cpu_dat_i       = '0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read_resume();
        test_bad_index();
        test_bp_resume();
        test_back_to_back();
`ifdef RISCV_DBG_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_riscv_dbg_sequencer

// File: doc/riscv_dbg_sequencer.md
RISCV_DBG_SEQUENCER -- requirements
Module: riscv_dbg_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 64, debug data width.
- PLEN, 64, debug address width.
- CORES_PER_TILE, 16, number of per-core debug ports.
- TIMEOUT, 255, ack-wait limit in cycles; used only with RISCV_DBG_TIMEOUT_EN.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all state updates on the rising edge.
- rstn, in, 1, reset; asynchronous, active-low.
- host_req_valid, in, 1, host command present.
- host_req_ready, out, 1, sequencer accepts a command.
- host_req_core, in, $clog2(CORES_PER_TILE)+1, target core index.
- host_req_we, in, 1, 1 = write, 0 = read.
- host_req_adr, in, PLEN, debug address.
- host_req_dat, in, XLEN, write data.
- host_req_resume, in, 1, release the core's stall after the access.
- host_rsp_valid, out, 1, one-cycle response pulse.
- host_rsp_dat, out, XLEN, read data.
- host_rsp_err, out, 1, access failed.
- cpu_bp_i, in, CORES_PER_TILE, per-core breakpoint.
- cpu_stall_o, out, CORES_PER_TILE, per-core stall.
- cpu_stb_o, out, CORES_PER_TILE, per-core debug strobe.
- cpu_we_o, out, CORES_PER_TILE, per-core write enable.
- cpu_adr_o, out, CORES_PER_TILE x PLEN, per-core address.
- cpu_dat_o, out, CORES_PER_TILE x XLEN, per-core write data.
- cpu_dat_i, in, CORES_PER_TILE x XLEN, per-core read data.
- cpu_ack_i, in, CORES_PER_TILE, per-core acknowledge.

Function
REQ-003 FSM states: IDLE, STALL, ACCESS, RESP; exactly one command outstanding.
REQ-004 IDLE: host_req_ready=1; on host_req_valid, capture all host_req_* fields and go to STALL; other states drive ready=0.
REQ-005 STALL (one cycle): set the sticky stall bit of the captured core; next state ACCESS.
REQ-006 ACCESS: assert cpu_stb_o/cpu_we_o/cpu_adr_o/cpu_dat_o only for the captured core; all other cores' stb=0.
REQ-007 ACCESS: when cpu_ack_i of the captured core is sampled high, capture cpu_dat_i (reads), deassert stb/we in the same edge, and go to RESP.
REQ-008 RESP: host_rsp_valid=1 for exactly one cycle with rsp_dat and rsp_err; if resume was captured, clear that core's sticky stall bit; next state IDLE.
REQ-009 Latency: command accepted at edge 0 -> stb high after edge 2; ack at edge N -> rsp_valid high after edge N+1.
REQ-010 cpu_stall_o[c] = cpu_bp_i[c] | stall_q[c]; cpu_bp_i[c] high also sets stall_q[c].
REQ-011 Breakpoint and resume clear on the same core in the same cycle: the set wins.
REQ-012 host_req_core >= CORES_PER_TILE: no stall and no bus activity; go IDLE -> RESP directly with rsp_err=1, rsp_dat=0.
REQ-013 Writes return rsp_dat=0; cpu_ack_i of non-selected cores is ignored.

Reset
REQ-014 With rstn low: FSM=IDLE, stall_q=0, all cpu_stb_o/cpu_we_o=0, cpu_adr_o/cpu_dat_o=0, host_rsp_valid=0, rsp_dat=0, rsp_err=0, timeout counter=0.
REQ-015 Reset mid-command aborts it with no response; after release, host_req_ready=1 on the first cycle.

Configuration
REQ-016 With RISCV_DBG_TIMEOUT_EN defined: count ACCESS cycles; when the count reaches TIMEOUT without ack, drop stb and go to RESP with rsp_err=1, rsp_dat=0, stall retained regardless of resume.
REQ-017 With RISCV_DBG_TIMEOUT_EN undefined: no counter is built, and ACCESS waits indefinitely.

Structure
REQ-018 The FSM state enum typedef resides in riscv_mpsoc_pkg.
REQ-019 The per-core sticky stall bank (set by bp/command, clear by resume, stall output) is the sub-module riscv_dbg_stall_ctrl.

Verification
REQ-020 Write: core 3, adr 0x10, dat 0xA5, ack 4 cycles after stb -> only cpu_stb_o[3] pulses, cpu_dat_o[3]=0xA5, rsp_valid with err=0, stall_o[3] stays 1 (resume=0).
REQ-021 Read with resume: core 0, cpu_dat_i[0]=0x1234 at ack -> rsp_dat=0x1234, err=0, stall_o[0] falls after the RESP edge.
REQ-022 Bad index: core=CORES_PER_TILE -> rsp_err=1 two cycles after acceptance, no stb on any core.
REQ-023 Breakpoint on core 5 concurrent with resume command on core 5 -> stall_o[5] remains 1.
REQ-024 Timeout (macro on, TIMEOUT=8, no ack) -> stb drops after 8 ACCESS cycles, rsp_err=1, and the next command is accepted.
REQ-025 Reset asserted during ACCESS -> stb=0 and stall_o=0 immediately, with no rsp_valid.
